// File: rtl/uart_rx_if.sv
// uart_rx_if: groups the serial input line and the parallel byte/status
// outputs of the UART receiver.
// master: the receiver itself (takes rx_in, drives the byte and flags).
// slave:  the line driver / byte consumer side.
interface uart_rx_if;
  logic       rx_in;
  logic       receive;
  logic [7:0] dout;
  logic       framing_error;
  logic       parity_error;
  logic       busy;

  modport master (
    input  rx_in,
    output receive,
    output dout,
    output framing_error,
    output parity_error,
    output busy
  );

  modport slave (
    output rx_in,
    input  receive,
    input  dout,
    input  framing_error,
    input  parity_error,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver, 1 start bit, 8 data bits LSB
// first, 1 stop bit. Each bit is sampled at mid-bit using a bit-period timer
// derived from CLK_FREQUENCY / BAUD_RATE. A completed byte is presented on
// dout with a one-cycle receive strobe plus framing/parity flags, which hold
// until the next completed frame.
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit
// between the last data bit and the stop bit. Without it the frame is 8N1
// and parity_error is tied to 0.
// BIT_TICKS must be at least 4; smaller values are not a legal configuration.
module uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.master bus
);

  localparam int BIT_TICKS  = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF_TICKS = BIT_TICKS / 32'sd2;
  localparam int TIMER_W    = $clog2(BIT_TICKS);

  // Timer compare points; only equality compares are used, so the timer
  // never needs to count past BIT_TICKS-1.
  localparam logic [TIMER_W-1:0] TIMER_BIT_END  = TIMER_W'(BIT_TICKS - 32'sd1);
  localparam logic [TIMER_W-1:0] TIMER_HALF_END = TIMER_W'(HALF_TICKS - 32'sd1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO     = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] TIMER_ONE      = TIMER_W'(1'b1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity of a data byte: 1 when the byte holds an odd number of ones.
  function automatic logic even_parity_f(input logic [7:0] data);
    return ^data;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  // Input conditioning
  logic               rx_meta_r;
  logic               rx_sync_r;
  logic               rx_prev_r;
  logic               start_edge_s;

  // FSM and datapath state
  state_t             state_r;
  state_t             state_s;
  logic [TIMER_W-1:0] timer_r;
  logic [TIMER_W-1:0] timer_s;
  logic [2:0]         bit_cnt_r;
  logic [2:0]         bit_cnt_s;
  logic [7:0]         shift_r;
  logic [7:0]         shift_s;
  logic               capture_s;

  // Registered outputs
  logic               receive_r;
  logic [7:0]         dout_r;
  logic               framing_error_r;
  logic               busy_r;

`ifdef UART_RX_PARITY_EN
  logic               parity_bit_r;
  logic               parity_bit_s;
  logic               parity_error_r;
`endif

  // Two-flop synchronizer for the asynchronous line plus a history flop for
  // falling-edge detection; all three idle high so reset never fakes a start.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= bus.rx_in;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // A start is a genuine high-to-low transition, so a line stuck low after a
  // broken frame cannot re-trigger until it has gone high again.
  assign start_edge_s = rx_prev_r & ~rx_sync_r;

  // FSM state, bit timer, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      timer_r   <= TIMER_ZERO;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
`ifdef UART_RX_PARITY_EN
      parity_bit_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
`ifdef UART_RX_PARITY_EN
      parity_bit_r <= parity_bit_s;
`endif
    end
  end

  // Next-state logic: sample mid-start-bit, then one sample per bit period;
  // the timer is cleared whenever a sample point is reached or the state
  // changes.
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    capture_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_s = parity_bit_r;
`endif

    case (state_r)
      IDLE: begin
        timer_s = TIMER_ZERO;
        if (start_edge_s) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end

      START: begin
        if (timer_r == TIMER_HALF_END) begin
          timer_s = TIMER_ZERO;
          if (rx_sync_r) begin
            // Line went back high before mid-start-bit: treat as a glitch.
            state_s = IDLE;
          end else begin
            state_s   = DATA;
            bit_cnt_s = 3'd0;
          end
        end else begin
          timer_s = timer_r + TIMER_ONE;
        end
      end

      DATA: begin
        if (timer_r == TIMER_BIT_END) begin
          timer_s   = TIMER_ZERO;
          shift_s   = {rx_sync_r, shift_r[7:1]};
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            state_s = DATA;
          end
        end else begin
          timer_s = timer_r + TIMER_ONE;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (timer_r == TIMER_BIT_END) begin
          timer_s      = TIMER_ZERO;
          parity_bit_s = rx_sync_r;
          state_s      = STOP;
        end else begin
          timer_s = timer_r + TIMER_ONE;
        end
      end
`endif

      STOP: begin
        if (timer_r == TIMER_BIT_END) begin
          // Leaving in the middle of the stop bit lets the next start edge
          // be caught even when frames follow with no idle gap.
          timer_s   = TIMER_ZERO;
          capture_s = 1'b1;
          state_s   = IDLE;
        end else begin
          timer_s = timer_r + TIMER_ONE;
        end
      end

      default: begin
        state_s   = IDLE;
        timer_s   = TIMER_ZERO;
        bit_cnt_s = 3'd0;
      end
    endcase
  end

  // Output registers: the byte and flags update together with the one-cycle
  // strobe and otherwise hold; busy tracks the state being entered so it
  // equals "FSM not idle" cycle-for-cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      receive_r       <= 1'b0;
      dout_r          <= 8'h00;
      framing_error_r <= 1'b0;
      busy_r          <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error_r  <= 1'b0;
`endif
    end else begin
      receive_r <= capture_s;
      busy_r    <= (state_s != IDLE);
      if (capture_s) begin
        dout_r          <= shift_r;
        framing_error_r <= ~rx_sync_r;
`ifdef UART_RX_PARITY_EN
        parity_error_r  <= even_parity_f(shift_r) ^ parity_bit_r;
`endif
      end
    end
  end

  assign bus.receive       = receive_r;
  assign bus.dout          = dout_r;
  assign bus.framing_error = framing_error_r;
  assign bus.busy          = busy_r;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error  = parity_error_r;
`else
  assign bus.parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 1 MHz / 100 kBd (10 clocks
// per bit). Frames push their expected byte/flags into a queue; a monitor
// pops and compares on every receive strobe.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_FREQUENCY = 1_000_000;
  localparam int BAUD_RATE     = 100_000;
  localparam int BIT_CYCLES    = 10;

  logic clk = 1'b0;
  logic reset;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQUENCY(CLK_FREQUENCY),
    .BAUD_RATE    (BAUD_RATE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dout;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t exp_q[$];
  int   checks      = 0;
  int   errors      = 0;
  int   pulses      = 0;
  int   cyc         = 0;
  int   last_rx_cyc = 0;
  int   fall_cyc    = 0;

  // Monitor: counts cycles and checks every receive strobe against the queue.
  always begin : monitor
    exp_t e;
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    if (bus.receive === 1'b1) begin
      pulses      = pulses + 1;
      last_rx_cyc = cyc;
      checks      = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_pulse got dout=%02h fe=%b pe=%b, no frame expected",
                 bus.dout, bus.framing_error, bus.parity_error);
      end else begin
        e = exp_q.pop_front();
        if (bus.dout !== e.dout || bus.framing_error !== e.fe || bus.parity_error !== e.pe) begin
          errors = errors + 1;
          $display("FAIL frame got dout=%02h fe=%b pe=%b expected dout=%02h fe=%b pe=%b",
                   bus.dout, bus.framing_error, bus.parity_error, e.dout, e.fe, e.pe);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.rx_in = b;
    repeat (BIT_CYCLES) @(negedge clk);
  endtask

  // One complete frame; pbit is only put on the line in the parity build.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic pbit,
                            input logic exp_fe, input logic exp_pe);
    exp_t e;
    e.dout = data;
    e.fe   = exp_fe;
    e.pe   = exp_pe;
    exp_q.push_back(e);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(pbit);
`else
    if (pbit === 1'bx) $display("note: parity bit argument unused in 8N1 build");
`endif
    send_bit(stop_bit);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_receive"}, {31'd0, bus.receive}, 32'd0);
    check({tag, "_dout"}, {24'd0, bus.dout}, 32'd0);
    check({tag, "_fe"}, {31'd0, bus.framing_error}, 32'd0);
    check({tag, "_pe"}, {31'd0, bus.parity_error}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int p;
    bus.rx_in = 1'b1;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    idle(20);

    // 1: single 0x55 frame, latency 98 clocks from the falling edge
    p = pulses;
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);
    check("t1_pulses", p + 1, pulses);
    check("t1_latency", last_rx_cyc - fall_cyc, 32'd98);
    check("t1_busy", {31'd0, bus.busy}, 32'd0);
    check("t1_dout_hold", {24'd0, bus.dout}, 32'h55);

    // 2: 3-cycle glitch is rejected
    p = pulses;
    bus.rx_in = 1'b0;
    repeat (3) @(negedge clk);
    bus.rx_in = 1'b1;
    repeat (8) @(negedge clk);
    check("t2_busy", {31'd0, bus.busy}, 32'd0);
    idle(20);
    check("t2_pulses", pulses, p);
    check("t2_dout_hold", {24'd0, bus.dout}, 32'h55);

    // 3: framing error, then line held low for 30 bit times
    p = pulses;
    send_frame(8'hA3, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.rx_in = 1'b0;
    repeat (30 * BIT_CYCLES) @(negedge clk);
    check("t3_pulses_low", pulses, p + 1);
    check("t3_busy_low", {31'd0, bus.busy}, 32'd0);
    check("t3_fe_hold", {31'd0, bus.framing_error}, 32'd1);
    idle(20);
    check("t3_pulses_high", pulses, p + 1);

    // 4: back-to-back frames with no idle gap
    p = pulses;
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);
    check("t4_pulses", pulses, p + 2);
    check("t4_dout", {24'd0, bus.dout}, 32'hFF);

    // 5: reset during data bit 4 of 0x81, then a clean 0x3C
    p = pulses;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    bus.rx_in = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    bus.rx_in = 1'b1;
    check_outputs_zero("t5_after_reset");
    idle(20);
    check("t5_no_pulse", pulses, p);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);
    check("t5_pulses", pulses, p + 1);
    check("t5_dout", {24'd0, bus.dout}, 32'h3C);

    // 6: parity (error expected only in the parity build)
    p = pulses;
`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(10);
    check("t6_pe_set", {31'd0, bus.parity_error}, 32'd1);
    send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
`else
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(10);
    check("t6_pe_zero", {31'd0, bus.parity_error}, 32'd0);
    send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    idle(20);
    check("t6_pe_final", {31'd0, bus.parity_error}, 32'd0);
    check("t6_pulses", pulses, p + 2);

    // Drain: every expected frame must have been seen.
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
